// File: rtl/ysyx_22041207_pkg.sv
// Shared constants and FSM encoding for the ysyx_22041207 fetch unit.
package ysyx_22041207_pkg;

    localparam int XLEN   = 64;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] IFU_RESET_PC = 64'h8000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: one outstanding request, REQ/WAIT/OUT handshake FSM.
module ysyx_22041207_ifu
    import ysyx_22041207_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    input  logic              stall_i,
    output logic              imem_req_valid_o,
    input  logic              imem_req_ready_i,
    output logic [XLEN-1:0]   imem_addr_o,
    input  logic              imem_rsp_valid_i,
    input  logic [INST_W-1:0] imem_rsp_data_i,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [XLEN-1:0]   pc_o
);

    ifu_state_e        state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic              drop_q, drop_d;
    logic              valid_q, valid_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   redir_pc;

    assign redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            fetch_pc_q <= RESET_PC;
            drop_q     <= 1'b0;
            valid_q    <= 1'b0;
            inst_q     <= '0;
            pc_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
        end
    end

    // Redirect wins everywhere; an in-flight response is marked for discard.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                    if (imem_req_ready_i) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (imem_req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                    if (imem_rsp_valid_i) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imem_rsp_valid_i) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = imem_rsp_data_i;
                        pc_d    = fetch_pc_q;
                        valid_d = 1'b1;
                        state_d = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (redirect_i) begin
                    fetch_pc_d = redir_pc;
                    valid_d    = 1'b0;
                    state_d    = S_REQ;
                end else if (!stall_i) begin
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    valid_d    = 1'b0;
                    state_d    = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_comb begin
        imem_req_valid_o = (state_q == S_REQ);
        imem_addr_o      = fetch_pc_q;
        valid_o          = valid_q;
        inst_o           = inst_q;
        pc_o             = pc_q;
    end

endmodule

// File: tb/tb_ysyx_22041207_ifu.sv
// Self-checking bench for ysyx_22041207_ifu: vector table plus corner sequences.
module tb_ysyx_22041207_ifu;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [63:0] redirect_pc_i;
    logic        stall_i;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [63:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [63:0] pc_o;

    ysyx_22041207_ifu dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .stall_i          (stall_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .valid_o          (valid_o),
        .inst_o           (inst_o),
        .pc_o             (pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          rdly;
        int          sdly;
        logic [31:0] inst;
        int          stall_n;
    } vec_t;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    vec_t        vecs[5];
    exp_t        exp_q[$];
    exp_t        e;
    logic [63:0] mpc;
    int          tests;
    int          fails;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Full transaction starting in REQ; model PC advances on delivery.
    task automatic do_fetch(input int rdly, input int sdly,
                            input logic [31:0] inst, input int stall_n);
        exp_t f;
        check("req_valid", imem_req_valid_o, 1);
        check("req_addr", imem_addr_o, mpc);
        for (int i = 0; i < rdly; i++) begin
            imem_req_ready_i = 1'b0;
            step();
            check("req_hold", imem_req_valid_o, 1);
        end
        imem_req_ready_i = 1'b1;
        step();
        imem_req_ready_i = 1'b0;
        check("wait_noreq", imem_req_valid_o, 0);
        for (int i = 0; i < sdly; i++) begin
            step();
            check("wait_novalid", valid_o, 0);
        end
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = inst;
        f.pc   = mpc;
        f.inst = inst;
        exp_q.push_back(f);
        step();
        imem_rsp_valid_i = 1'b0;
        stall_i = (stall_n > 0);
        for (int i = 0; i < stall_n; i++) begin
            check("stall_valid", valid_o, 1);
            check("stall_pc", pc_o, exp_q[0].pc);
            check("stall_inst", inst_o, exp_q[0].inst);
            check("stall_noreq", imem_req_valid_o, 0);
            step();
        end
        stall_i = 1'b0;
        f = exp_q.pop_front();
        check("out_valid", valid_o, 1);
        check("out_pc", pc_o, f.pc);
        check("out_inst", inst_o, f.inst);
        step();
        mpc = mpc + 64'd4;
        check("consumed_valid", valid_o, 0);
        check("next_addr", imem_addr_o, mpc);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        stall_i = 1'b0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i = '0;
        mpc = 64'h8000_0000;

        vecs[0] = '{0, 0, 32'h0000_0413, 0};
        vecs[1] = '{0, 0, 32'h0010_0093, 5};
        vecs[2] = '{2, 1, 32'h0020_8113, 0};
        vecs[3] = '{1, 3, 32'h0031_0193, 2};
        vecs[4] = '{0, 2, 32'hFFFF_FFFF, 1};

        #2;
        check("rst_valid", valid_o, 0);
        check("rst_inst", inst_o, 0);
        check("rst_pc", pc_o, 0);
        check("rst_req", imem_req_valid_o, 1);
        check("rst_addr", imem_addr_o, 64'h8000_0000);
        step();
        step();
        rst = 1'b0;

        for (int k = 0; k < 5; k++)
            do_fetch(vecs[k].rdly, vecs[k].sdly, vecs[k].inst, vecs[k].stall_n);

        // Response outside WAIT is ignored.
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'h1234_5678;
        step();
        imem_rsp_valid_i = 1'b0;
        check("stray_rsp_valid", valid_o, 0);
        check("stray_rsp_req", imem_req_valid_o, 1);

        // Redirect in WAIT, response later is dropped.
        imem_req_ready_i = 1'b1;
        step();
        imem_req_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 64'h8000_1002;
        step();
        redirect_i = 1'b0;
        check("wredir_still_wait", imem_req_valid_o, 0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid_i = 1'b0;
        check("wredir_valid", valid_o, 0);
        check("wredir_req", imem_req_valid_o, 1);
        check("wredir_addr", imem_addr_o, 64'h8000_1000);
        mpc = 64'h8000_1000;
        do_fetch(0, 0, 32'h0000_0013, 0);

        // Redirect with same-cycle response in WAIT.
        imem_req_ready_i = 1'b1;
        step();
        imem_req_ready_i = 1'b0;
        redirect_i = 1'b1;
        redirect_pc_i = 64'h8000_0203;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i = 32'hBAD0_BAD0;
        step();
        redirect_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        check("wrsp_redir_valid", valid_o, 0);
        check("wrsp_redir_addr", imem_addr_o, 64'h8000_0200);
        check("wrsp_redir_req", imem_req_valid_o, 1);

        // Redirect in REQ with same-cycle handshake.
        imem_req_ready_i = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 64'h8000_2000;
        step();
        imem_req_ready_i = 1'b0;
        redirect_i = 1'b0;
        check("rredir_wait", imem_req_valid_o, 0);
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i = 32'hCAFE_0001;
        step();
        imem_rsp_valid_i = 1'b0;
        check("rredir_valid", valid_o, 0);
        check("rredir_addr", imem_addr_o, 64'h8000_2000);
        mpc = 64'h8000_2000;
        do_fetch(0, 0, 32'h0040_0213, 0);

        // Redirect in OUT with no stall: instruction not delivered.
        imem_req_ready_i = 1'b1;
        step();
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i = 32'h0050_0293;
        step();
        imem_rsp_valid_i = 1'b0;
        check("oredir_pre_valid", valid_o, 1);
        check("oredir_pre_pc", pc_o, mpc);
        redirect_i = 1'b1;
        redirect_pc_i = 64'h8000_0100;
        step();
        redirect_i = 1'b0;
        check("oredir_valid", valid_o, 0);
        check("oredir_req", imem_req_valid_o, 1);
        check("oredir_addr", imem_addr_o, 64'h8000_0100);

        // PC wrap at the top of the address space.
        redirect_i = 1'b1;
        redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        redirect_i = 1'b0;
        mpc = 64'hFFFF_FFFF_FFFF_FFFC;
        do_fetch(0, 0, 32'h0060_0313, 0);
        check("wrap_addr", imem_addr_o, 64'h0);

        // Reset during WAIT, late response after release is ignored.
        imem_req_ready_i = 1'b1;
        step();
        imem_req_ready_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_req", imem_req_valid_o, 1);
        check("arst_addr", imem_addr_o, 64'h8000_0000);
        step();
        rst = 1'b0;
        imem_rsp_valid_i = 1'b1;
        imem_rsp_data_i = 32'h7777_7777;
        step();
        imem_rsp_valid_i = 1'b0;
        check("late_rsp_valid", valid_o, 0);
        check("late_rsp_req", imem_req_valid_o, 1);
        check("late_rsp_addr", imem_addr_o, 64'h8000_0000);
        mpc = 64'h8000_0000;
        do_fetch(0, 0, 32'h0000_0413, 0);

        check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
